// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: fetch/exec/commit sequencer that drives ALU select and operand controls,
// waits a programmable settle time for the combinational ALU, then commits a register write
// or a branch/jump decision and advances the program counter.
module alu_issue_ctrl #(
   parameter int unsigned ALU_WAIT = 2,             // EXEC cycles, legal range 1..15
   parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [31:0] INSTRUCTION,
   input  logic        INSTR_VALID,
   output logic        INSTR_READY,
   input  logic [7:0]  ALU_RESULT,
   input  logic        ALU_ZERO,
   output logic [2:0]  ALUOP,
   output logic [2:0]  READREG1,
   output logic [2:0]  READREG2,
   output logic [2:0]  WRITEREG,
   output logic        WRITEENABLE,
   output logic [7:0]  IMMEDIATE,
   output logic        IMM_SEL,
   output logic        NEG_SEL,
   output logic [31:0] PC,
   output logic [7:0]  LAST_RESULT,
   output logic        ILLEGAL
);

   typedef enum logic [1:0] {StFetch, StExec, StCommit} state_e;

   localparam logic [3:0] WaitLoad = 4'(ALU_WAIT - 1);

   localparam logic [7:0] OpLoadi = 8'h00;
   localparam logic [7:0] OpMov   = 8'h01;
   localparam logic [7:0] OpAdd   = 8'h02;
   localparam logic [7:0] OpSub   = 8'h03;
   localparam logic [7:0] OpAnd   = 8'h04;
   localparam logic [7:0] OpOr    = 8'h05;
   localparam logic [7:0] OpJ     = 8'h06;
   localparam logic [7:0] OpBeq   = 8'h07;

   localparam logic [2:0] AluFwd = 3'b000;
   localparam logic [2:0] AluAdd = 3'b001;
   localparam logic [2:0] AluAnd = 3'b010;
   localparam logic [2:0] AluOr  = 3'b011;

   state_e      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        accept;

   // Combinational decode of the incoming instruction, captured on the accept edge
   logic [2:0]  dec_aluop;
   logic        dec_imm_sel;
   logic        dec_neg_sel;
   logic        dec_write;
   logic        dec_jump;
   logic        dec_beq;
   logic        dec_illegal;

   // Registered decode, held from the first EXEC cycle until the next accept
   logic [2:0]  aluop_q;
   logic [2:0]  readreg1_q;
   logic [2:0]  readreg2_q;
   logic [2:0]  writereg_q;
   logic [7:0]  imm_q;
   logic [7:0]  off_q;
   logic        imm_sel_q;
   logic        neg_sel_q;
   logic        write_q;
   logic        jump_q;
   logic        beq_q;
   logic        illegal_op_q;

   // Commit-cycle strobes and architectural state
   logic        we_q, we_d;
   logic        illegal_q, illegal_d;
   logic [31:0] pc_q, pc_d;
   logic [7:0]  last_result_q, last_result_d;
   logic        taken;
   logic [31:0] branch_ofs;

   // Register-address bits above [2:0] are deliberately ignored (x0..x7 only)
   logic        unused_instr_bits;
   assign unused_instr_bits = ^INSTRUCTION[15:11];

   assign accept = (state_q == StFetch) && INSTR_VALID;

   // Opcode decode table
   always_comb begin
      dec_aluop   = AluFwd;
      dec_imm_sel = 1'b0;
      dec_neg_sel = 1'b0;
      dec_write   = 1'b0;
      dec_jump    = 1'b0;
      dec_beq     = 1'b0;
      dec_illegal = 1'b0;
      case (INSTRUCTION[31:24])
         OpLoadi: begin
            dec_imm_sel = 1'b1;
            dec_write   = 1'b1;
         end
         OpMov: begin
            dec_write   = 1'b1;
         end
         OpAdd: begin
            dec_aluop   = AluAdd;
            dec_write   = 1'b1;
         end
         OpSub: begin
            dec_aluop   = AluAdd;
            dec_neg_sel = 1'b1;
            dec_write   = 1'b1;
         end
         OpAnd: begin
            dec_aluop   = AluAnd;
            dec_write   = 1'b1;
         end
         OpOr: begin
            dec_aluop   = AluOr;
            dec_write   = 1'b1;
         end
         OpJ: begin
            dec_jump    = 1'b1;
         end
         OpBeq: begin
            // Compare by subtraction; ZERO flag decides at commit
            dec_aluop   = AluAdd;
            dec_neg_sel = 1'b1;
            dec_beq     = 1'b1;
         end
         default: begin
            dec_illegal = 1'b1;
         end
      endcase
   end

   // Decode output registers: cleared by reset, loaded on accept, otherwise held
   always_ff @(posedge CLK) begin
      if (RESET) begin
         aluop_q      <= 3'b000;
         readreg1_q   <= 3'b000;
         readreg2_q   <= 3'b000;
         writereg_q   <= 3'b000;
         imm_q        <= 8'h00;
         off_q        <= 8'h00;
         imm_sel_q    <= 1'b0;
         neg_sel_q    <= 1'b0;
         write_q      <= 1'b0;
         jump_q       <= 1'b0;
         beq_q        <= 1'b0;
         illegal_op_q <= 1'b0;
      end else if (accept) begin
         aluop_q      <= dec_aluop;
         readreg1_q   <= INSTRUCTION[10:8];
         readreg2_q   <= INSTRUCTION[2:0];
         writereg_q   <= INSTRUCTION[18:16];
         imm_q        <= INSTRUCTION[7:0];
         off_q        <= INSTRUCTION[23:16];
         imm_sel_q    <= dec_imm_sel;
         neg_sel_q    <= dec_neg_sel;
         write_q      <= dec_write;
         jump_q       <= dec_jump;
         beq_q        <= dec_beq;
         illegal_op_q <= dec_illegal;
      end
   end

   // Sign-extended word offset; 8'hFF yields -4 which cancels the +4
   assign branch_ofs = {{22{off_q[7]}}, off_q, 2'b00};
   assign taken      = jump_q | (beq_q & ALU_ZERO);

   // Next-state, settle counter and commit-side next values
   always_comb begin
      state_d       = state_q;
      cnt_d         = cnt_q;
      we_d          = 1'b0;
      illegal_d     = 1'b0;
      pc_d          = pc_q;
      last_result_d = last_result_q;
      unique case (state_q)
         StFetch: begin
            if (INSTR_VALID) begin
               cnt_d   = WaitLoad;
               state_d = StExec;
            end
         end
         StExec: begin
            if (cnt_q == 4'd0) begin
               // Strobes are registered so they are high for exactly the COMMIT cycle
               we_d      = write_q;
               illegal_d = illegal_op_q;
               state_d   = StCommit;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StCommit: begin
            last_result_d = ALU_RESULT;
            pc_d          = pc_q + 32'd4 + (taken ? branch_ofs : 32'd0);
            state_d       = StFetch;
         end
         default: begin
            state_d = StFetch;
         end
      endcase
   end

   // State, counter, PC and commit strobes; reset aborts any in-flight instruction
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q       <= StFetch;
         cnt_q         <= 4'd0;
         we_q          <= 1'b0;
         illegal_q     <= 1'b0;
         pc_q          <= PC_RESET;
         last_result_q <= 8'h00;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         we_q          <= we_d;
         illegal_q     <= illegal_d;
         pc_q          <= pc_d;
         last_result_q <= last_result_d;
      end
   end

   // Output drive
   always_comb begin
      INSTR_READY = (state_q == StFetch);
      ALUOP       = aluop_q;
      READREG1    = readreg1_q;
      READREG2    = readreg2_q;
      WRITEREG    = writereg_q;
      WRITEENABLE = we_q;
      IMMEDIATE   = imm_q;
      IMM_SEL     = imm_sel_q;
      NEG_SEL     = neg_sel_q;
      PC          = pc_q;
      LAST_RESULT = last_result_q;
      ILLEGAL     = illegal_q;
   end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed vectors with hand-computed expectations for alu_issue_ctrl
// (ALU_WAIT = 2, PC_RESET = 0). Inputs change #1 after the rising edge; outputs are checked then.
module tb_alu_issue_ctrl;

   localparam int unsigned AluWait = 2;

   logic        CLK;
   logic        RESET;
   logic [31:0] INSTRUCTION;
   logic        INSTR_VALID;
   logic        INSTR_READY;
   logic [7:0]  ALU_RESULT;
   logic        ALU_ZERO;
   logic [2:0]  ALUOP;
   logic [2:0]  READREG1;
   logic [2:0]  READREG2;
   logic [2:0]  WRITEREG;
   logic        WRITEENABLE;
   logic [7:0]  IMMEDIATE;
   logic        IMM_SEL;
   logic        NEG_SEL;
   logic [31:0] PC;
   logic [7:0]  LAST_RESULT;
   logic        ILLEGAL;

   int checks;
   int failures;

   alu_issue_ctrl #(
      .ALU_WAIT (AluWait),
      .PC_RESET (32'h0000_0000)
   ) u_dut (
      .CLK         (CLK),
      .RESET       (RESET),
      .INSTRUCTION (INSTRUCTION),
      .INSTR_VALID (INSTR_VALID),
      .INSTR_READY (INSTR_READY),
      .ALU_RESULT  (ALU_RESULT),
      .ALU_ZERO    (ALU_ZERO),
      .ALUOP       (ALUOP),
      .READREG1    (READREG1),
      .READREG2    (READREG2),
      .WRITEREG    (WRITEREG),
      .WRITEENABLE (WRITEENABLE),
      .IMMEDIATE   (IMMEDIATE),
      .IMM_SEL     (IMM_SEL),
      .NEG_SEL     (NEG_SEL),
      .PC          (PC),
      .LAST_RESULT (LAST_RESULT),
      .ILLEGAL     (ILLEGAL)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Bounded wait for FETCH
   task automatic wait_ready();
      int n;
      n = 0;
      while (INSTR_READY !== 1'b1 && n < 16) begin
         step();
         n++;
      end
      check("ready_wait", {31'd0, INSTR_READY}, 32'd1);
   endtask

   // Present one instruction in FETCH; returns in the first EXEC cycle
   task automatic issue(input logic [31:0] instr, input logic [7:0] res, input logic zero);
      wait_ready();
      INSTRUCTION = instr;
      INSTR_VALID = 1'b1;
      ALU_RESULT  = res;
      ALU_ZERO    = zero;
      step();
      INSTR_VALID = 1'b0;
   endtask

   // From the first EXEC cycle to the COMMIT cycle
   task automatic to_commit();
      repeat (AluWait) step();
   endtask

   // Issue, run to COMMIT, check strobes, step into FETCH and check PC
   task automatic run_ctrl(input string tag, input logic [31:0] instr, input logic zero,
                           input logic exp_ill, input logic [31:0] exp_pc);
      issue(instr, 8'h00, zero);
      to_commit();
      check({tag, "_we"}, {31'd0, WRITEENABLE}, 32'd0);
      check({tag, "_ill"}, {31'd0, ILLEGAL}, {31'd0, exp_ill});
      step();
      check({tag, "_pc"}, PC, exp_pc);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      checks      = 0;
      failures    = 0;
      RESET       = 1'b1;
      INSTRUCTION = 32'h0;
      INSTR_VALID = 1'b0;
      ALU_RESULT  = 8'h00;
      ALU_ZERO    = 1'b0;
      step();
      step();
      RESET = 1'b0;

      // Reset state
      check("rst_ready", {31'd0, INSTR_READY}, 32'd1);
      check("rst_pc", PC, 32'h0);
      check("rst_we", {31'd0, WRITEENABLE}, 32'd0);
      check("rst_aluop", {29'd0, ALUOP}, 32'd0);
      check("rst_imm", {24'd0, IMMEDIATE}, 32'd0);
      check("rst_last", {24'd0, LAST_RESULT}, 32'd0);
      check("rst_ill", {31'd0, ILLEGAL}, 32'd0);

      // 1: loadi with INSTR_VALID held
      INSTRUCTION = 32'h0004_0017;
      INSTR_VALID = 1'b1;
      step();
      check("t1_ready_e1", {31'd0, INSTR_READY}, 32'd0);
      check("t1_imm", {24'd0, IMMEDIATE}, 32'h17);
      check("t1_imm_sel", {31'd0, IMM_SEL}, 32'd1);
      check("t1_wreg", {29'd0, WRITEREG}, 32'd4);
      check("t1_aluop", {29'd0, ALUOP}, 32'd0);
      check("t1_we_e1", {31'd0, WRITEENABLE}, 32'd0);
      step();
      check("t1_ready_e2", {31'd0, INSTR_READY}, 32'd0);
      check("t1_we_e2", {31'd0, WRITEENABLE}, 32'd0);
      step();
      check("t1_ready_c", {31'd0, INSTR_READY}, 32'd0);
      check("t1_we_c", {31'd0, WRITEENABLE}, 32'd1);
      check("t1_pc_c", PC, 32'h0);
      step();
      check("t1_ready_f", {31'd0, INSTR_READY}, 32'd1);
      check("t1_we_f", {31'd0, WRITEENABLE}, 32'd0);
      check("t1_pc_f", PC, 32'h4);

      // 2: sub accepted from the still-held INSTR_VALID, 4 cycles after the first accept
      INSTRUCTION = 32'h0302_0105;
      ALU_RESULT  = 8'hFE;
      step();
      INSTR_VALID = 1'b0;
      check("t2_ready", {31'd0, INSTR_READY}, 32'd0);
      check("t2_aluop", {29'd0, ALUOP}, 32'd1);
      check("t2_neg", {31'd0, NEG_SEL}, 32'd1);
      check("t2_imm_sel", {31'd0, IMM_SEL}, 32'd0);
      check("t2_rr1", {29'd0, READREG1}, 32'd1);
      check("t2_rr2", {29'd0, READREG2}, 32'd5);
      check("t2_wreg", {29'd0, WRITEREG}, 32'd2);
      to_commit();
      check("t2_we", {31'd0, WRITEENABLE}, 32'd1);
      step();
      check("t2_last", {24'd0, LAST_RESULT}, 32'hFE);
      check("t2_pc", PC, 32'h8);

      // 3: beq taken from PC 8 -> 24, j back to 8, beq not taken -> 12
      issue(32'h0703_0102, 8'h00, 1'b1);
      check("t3_aluop", {29'd0, ALUOP}, 32'd1);
      check("t3_neg", {31'd0, NEG_SEL}, 32'd1);
      to_commit();
      check("t3_we_t", {31'd0, WRITEENABLE}, 32'd0);
      step();
      check("t3_pc_t", PC, 32'h18);
      run_ctrl("t3_jback", 32'h06FB_0000, 1'b0, 1'b0, 32'h8);
      run_ctrl("t3_nt", 32'h0703_0102, 1'b0, 1'b0, 32'hC);

      // 4: j to 0x40, then off FE -> 0x3C, off FF -> unchanged
      run_ctrl("t4_j40", 32'h060C_0000, 1'b0, 1'b0, 32'h40);
      run_ctrl("t4_jfe", 32'h06FE_0000, 1'b0, 1'b0, 32'h3C);
      run_ctrl("t4_jff", 32'h06FF_0000, 1'b1, 1'b0, 32'h3C);

      // 5: illegal opcode, then j to 0xFFFF_FFFC and loadi wraps to 0
      run_ctrl("t5_ill", 32'hA500_0000, 1'b1, 1'b1, 32'h40);
      check("t5_ill_off", {31'd0, ILLEGAL}, 32'd0);
      run_ctrl("t5_jneg", 32'h06EE_0000, 1'b0, 1'b0, 32'hFFFF_FFFC);
      issue(32'h0001_0033, 8'h33, 1'b0);
      to_commit();
      check("t5_we", {31'd0, WRITEENABLE}, 32'd1);
      step();
      check("t5_wrap", PC, 32'h0);

      // and / or / mov decode
      issue(32'h0403_0102, 8'h11, 1'b0);
      check("and_aluop", {29'd0, ALUOP}, 32'd2);
      check("and_neg", {31'd0, NEG_SEL}, 32'd0);
      to_commit();
      check("and_we", {31'd0, WRITEENABLE}, 32'd1);
      step();
      issue(32'h0504_0102, 8'h22, 1'b0);
      check("or_aluop", {29'd0, ALUOP}, 32'd3);
      to_commit();
      step();
      issue(32'h0105_0600, 8'h5A, 1'b0);
      check("mov_aluop", {29'd0, ALUOP}, 32'd0);
      check("mov_imm_sel", {31'd0, IMM_SEL}, 32'd0);
      check("mov_rr1", {29'd0, READREG1}, 32'd6);
      to_commit();
      check("mov_we", {31'd0, WRITEENABLE}, 32'd1);
      step();
      check("mov_last", {24'd0, LAST_RESULT}, 32'h5A);
      check("mov_pc", PC, 32'hC);

      // 6: reset in the second EXEC cycle of an add
      issue(32'h0206_0107, 8'h77, 1'b0);
      check("t6_aluop", {29'd0, ALUOP}, 32'd1);
      step();
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      check("t6_ready", {31'd0, INSTR_READY}, 32'd1);
      check("t6_pc", PC, 32'h0);
      check("t6_we", {31'd0, WRITEENABLE}, 32'd0);
      check("t6_aluop0", {29'd0, ALUOP}, 32'd0);
      check("t6_wreg", {29'd0, WRITEREG}, 32'd0);
      check("t6_rr1", {29'd0, READREG1}, 32'd0);
      check("t6_rr2", {29'd0, READREG2}, 32'd0);
      check("t6_imm", {24'd0, IMMEDIATE}, 32'd0);
      check("t6_last", {24'd0, LAST_RESULT}, 32'd0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("t6_idle_we", {31'd0, WRITEENABLE}, 32'd0);
         check("t6_idle_pc", PC, 32'h0);
      end
      run_ctrl("t6_recover", 32'h0600_0000, 1'b0, 1'b0, 32'h4);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
Sequencing control unit that produces the ALU operation and operands and consumes the ALU's result and zero flag.
- Accepts one 32-bit instruction per handshake from the fetch side.
- Decodes it into ALU select, register-file read/write addresses, immediate and negate controls.
- Waits a programmable settle time for the combinational ALU, then commits: register write-enable, or a branch/jump decision from the ZERO flag.
- Owns the program counter.

Parameters:
ALU_WAIT, 2, EXEC-state cycles for ALU settle; legal range 1..15.
PC_RESET, 32'h0000_0000, PC value after reset.

Ports:
CLK  input  1  rising-edge clock
RESET  input  1  synchronous, active-high reset
INSTRUCTION  input  32  [31:24] opcode, [23:16] dest/offset, [15:8] src1, [7:0] src2/immediate
INSTR_VALID  input  1  INSTRUCTION valid
INSTR_READY  output  1  unit can accept an instruction (high only in FETCH)
ALU_RESULT  input  8  ALU result (observed for debug capture)
ALU_ZERO  input  1  ALU zero flag
ALUOP  output  3  ALU select: 000 fwd, 001 add, 010 and, 011 or
READREG1  output  3  register-file read address 1 = INSTRUCTION[10:8]
READREG2  output  3  register-file read address 2 = INSTRUCTION[2:0]
WRITEREG  output  3  register-file write address = INSTRUCTION[18:16]
WRITEENABLE  output  1  register write strobe, one cycle
IMMEDIATE  output  8  INSTRUCTION[7:0]
IMM_SEL  output  1  1 = ALU DATA2 from IMMEDIATE
NEG_SEL  output  1  1 = DATA2 two's-complement negated
PC  output  32  program counter
LAST_RESULT  output  8  ALU_RESULT sampled at COMMIT
ILLEGAL  output  1  one-cycle pulse on unknown opcode

Behaviour:
- Reset (synchronous, RESET high at CLK edge):
  - state = FETCH; PC = PC_RESET.
  - All other outputs 0, except INSTR_READY = 1.
  - Reset wins over every other event, including mid-EXEC or mid-COMMIT; no write or PC update occurs from the aborted instruction.
- States: FETCH -> EXEC -> COMMIT -> FETCH.
- FETCH:
  - INSTR_READY = 1.
  - On an edge with INSTR_VALID = 1: latch INSTRUCTION, load counter = ALU_WAIT-1, go to EXEC.
  - Otherwise stay; outputs hold previous decode values, WRITEENABLE = 0.
- EXEC:
  - Decode outputs are registered from the latched instruction, valid from the first EXEC cycle, and stable through COMMIT.
  - Counter decrements each cycle; on counter == 0, go to COMMIT.
  - EXEC lasts exactly ALU_WAIT cycles.
- COMMIT (1 cycle):
  - WRITEENABLE = 1 only for loadi/mov/add/sub/and/or.
  - LAST_RESULT <= ALU_RESULT.
  - Branch decision is sampled from ALU_ZERO in this cycle.
  - PC updates on the exiting edge; next state is FETCH.
- Throughput: one instruction per ALU_WAIT+2 cycles, minimum. INSTR_VALID is ignored outside FETCH; a held INSTR_VALID is accepted again on return to FETCH.
- Opcode decode:
  - 00 loadi: ALUOP 000, IMM_SEL 1, write.
  - 01 mov: ALUOP 000, IMM_SEL 0, write.
  - 02 add: ALUOP 001, write.
  - 03 sub: ALUOP 001, NEG_SEL 1, write.
  - 04 and: ALUOP 010, write.
  - 05 or: ALUOP 011, write.
  - 06 j: no write; always taken.
  - 07 beq: ALUOP 001, NEG_SEL 1, no write; taken iff ALU_ZERO = 1 at COMMIT.
  - Other opcodes: ALUOP 000, no write, ILLEGAL pulses for the COMMIT cycle, PC += 4.
- PC arithmetic:
  - Not taken: PC <= PC + 4.
  - Taken: PC <= PC + 4 + ({{22{off[7]}}, off, 2'b00}), where off = INSTRUCTION[23:16].
  - 32-bit modulo wrap; no overflow flag.
  - Negative offsets are legal (off = 8'hFF gives PC unchanged).
- Registers x0..x7 only; address bits above [2:0] are ignored.

Test Plan:
1. Reset then loadi, INSTRUCTION = 32'h0004_0017, ALU_WAIT = 2, with INSTR_VALID held:
   - INSTR_READY drops for 3 cycles.
   - During EXEC: IMMEDIATE = 8'h17, IMM_SEL = 1, WRITEREG = 4.
   - WRITEENABLE high exactly 1 cycle.
   - PC 0 -> 4; next accept 4 cycles after the first.
2. sub, INSTRUCTION = 32'h0302_0105:
   - ALUOP = 001, NEG_SEL = 1, READREG1 = 1, READREG2 = 5, WRITEREG = 2.
   - With ALU_RESULT = 8'hFE at COMMIT, LAST_RESULT = 8'hFE.
3. beq, off = 8'h03, ALU_ZERO = 1 at COMMIT, PC = 8:
   - PC -> 8 + 4 + 12 = 24.
   - Repeat with ALU_ZERO = 0: PC -> 12. WRITEENABLE stays 0 in both cases.
4. j with off = 8'hFE from PC = 32'h40:
   - PC -> 32'h3C.
   - j with off = 8'hFF: PC unchanged.
5. Opcode 8'hA5:
   - ILLEGAL pulses 1 cycle, WRITEENABLE 0, PC += 4.
   - Also: PC = 32'hFFFF_FFFC with loadi -> PC wraps to 0.
6. RESET asserted in second EXEC cycle of an add:
   - Next cycle state FETCH, INSTR_READY = 1, PC = 0, WRITEENABLE never asserted, all decode outputs 0.
